// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues single-outstanding fetches to
// instruction memory and presents fetched words to decode over valid/ready.
module fetch_sequencer #(
    parameter int unsigned         PC_WIDTH    = 64,
    parameter int unsigned         INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   Clk,
    input  logic                   reset_n,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic [INSTR_WIDTH-1:0] out_instr
);

    localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_VALID,
        ST_DRAIN
    } state_e;

    state_e                 state_q,     state_d;
    logic [PC_WIDTH-1:0]    pending_pc_q, pending_pc_d;
    logic                   imem_req_q,  imem_req_d;
    logic [PC_WIDTH-1:0]    imem_addr_q, imem_addr_d;
    logic                   out_valid_q, out_valid_d;
    logic [PC_WIDTH-1:0]    out_pc_q,    out_pc_d;
    logic [INSTR_WIDTH-1:0] out_instr_q, out_instr_d;

    logic                   ack_c;
    logic [PC_WIDTH-1:0]    redirect_tgt_c;

    // An ack only counts while a request is actually outstanding.
    assign ack_c          = imem_ack && imem_req_q;
    assign redirect_tgt_c = redirect_pc & ALIGN_MASK;

    // Next-state and output computation; redirect has priority everywhere.
    always_comb begin
        state_d      = state_q;
        pending_pc_d = pending_pc_q;
        imem_req_d   = imem_req_q;
        imem_addr_d  = imem_addr_q;
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_instr_d  = out_instr_q;

        case (state_q)
            ST_BOOT: begin
                state_d    = ST_FETCH;
                imem_req_d = 1'b1;
                if (redirect_valid) begin
                    pending_pc_d = redirect_tgt_c;
                    imem_addr_d  = redirect_tgt_c;
                end else begin
                    imem_addr_d  = pending_pc_q;
                end
            end

            ST_FETCH: begin
                if (redirect_valid) begin
                    pending_pc_d = redirect_tgt_c;
                    if (ack_c) begin
                        // Response lands with the redirect: drop it, refetch now.
                        state_d     = ST_FETCH;
                        imem_addr_d = redirect_tgt_c;
                    end else begin
                        // Request cannot be withdrawn; wait for its ack and discard.
                        state_d     = ST_DRAIN;
                    end
                end else if (ack_c) begin
                    state_d      = ST_VALID;
                    imem_req_d   = 1'b0;
                    out_valid_d  = 1'b1;
                    out_pc_d     = imem_addr_q;
                    out_instr_d  = imem_rdata;
                    pending_pc_d = imem_addr_q + PC_STEP;
                end
            end

            ST_VALID: begin
                if (redirect_valid) begin
                    state_d      = ST_FETCH;
                    out_valid_d  = 1'b0;
                    pending_pc_d = redirect_tgt_c;
                    imem_req_d   = 1'b1;
                    imem_addr_d  = redirect_tgt_c;
                end else if (out_ready) begin
                    state_d     = ST_FETCH;
                    out_valid_d = 1'b0;
                    imem_req_d  = 1'b1;
                    imem_addr_d = pending_pc_q;
                end
            end

            ST_DRAIN: begin
                if (redirect_valid) begin
                    pending_pc_d = redirect_tgt_c;
                end
                if (ack_c) begin
                    state_d     = ST_FETCH;
                    imem_addr_d = redirect_valid ? redirect_tgt_c : pending_pc_q;
                end
            end

            default: begin
                state_d    = ST_BOOT;
                imem_req_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_BOOT;
            pending_pc_q <= RESET_PC;
            imem_req_q   <= 1'b0;
            imem_addr_q  <= RESET_PC;
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_instr_q  <= '0;
        end else begin
            state_q      <= state_d;
            pending_pc_q <= pending_pc_d;
            imem_req_q   <= imem_req_d;
            imem_addr_q  <= imem_addr_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_instr_q  <= out_instr_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_instr = out_instr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table plus randomized run against a
// transaction-level reference model with a variable-latency memory.
module tb_fetch_sequencer;

    localparam int unsigned PW = 64;
    localparam int unsigned IW = 32;

    logic          Clk;
    logic          reset_n;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_rdata;
    logic          redirect_valid;
    logic [PW-1:0] redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_pc;
    logic [IW-1:0] out_instr;

    int total = 0;
    int bad   = 0;

    fetch_sequencer #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC('0)) dut (
        .Clk            (Clk),
        .reset_n        (reset_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic          ack;
        logic [IW-1:0] rdata;
        logic          rv;
        logic [PW-1:0] rpc;
        logic          rdy;
        logic          e_req;
        logic [PW-1:0] e_addr;
        logic          e_ov;
        logic [PW-1:0] e_pc;
        logic [IW-1:0] e_instr;
    } vec_t;

    vec_t vecs[$];

    task automatic row(input logic ack, input logic [IW-1:0] rdata, input logic rv,
                       input logic [PW-1:0] rpc, input logic rdy, input logic e_req,
                       input logic [PW-1:0] e_addr, input logic e_ov,
                       input logic [PW-1:0] e_pc, input logic [IW-1:0] e_instr);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_ov = e_ov; v.e_pc = e_pc; v.e_instr = e_instr;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic e_req, input logic [PW-1:0] e_addr,
                         input logic e_ov, input logic [PW-1:0] e_pc, input logic [IW-1:0] e_instr);
        total++;
        if ({imem_req, imem_addr, out_valid, out_pc, out_instr} !==
            {e_req, e_addr, e_ov, e_pc, e_instr}) begin
            bad++;
            $display("FAIL %s: got req=%0b addr=%h valid=%0b pc=%h instr=%h, want req=%0b addr=%h valid=%0b pc=%h instr=%h",
                     name, imem_req, imem_addr, out_valid, out_pc, out_instr,
                     e_req, e_addr, e_ov, e_pc, e_instr);
        end
    endtask

    task automatic drive(input logic ack, input logic [IW-1:0] rdata, input logic rv,
                         input logic [PW-1:0] rpc, input logic rdy);
        imem_ack       = ack;
        imem_rdata     = rdata;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
    endtask

    function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    // Reference model state: outstanding request, discard flag, presented instruction.
    logic          m_started, m_req, m_flush, m_ov;
    logic [PW-1:0] m_addr, m_pend, m_pc;
    logic [IW-1:0] m_instr;

    task automatic model_reset();
        m_started = 1'b0; m_req = 1'b0; m_flush = 1'b0; m_ov = 1'b0;
        m_addr = '0; m_pend = '0; m_pc = '0; m_instr = '0;
    endtask

    task automatic model_step(input logic ack_in, input logic [IW-1:0] rdata,
                              input logic rv, input logic [PW-1:0] rpc, input logic rdy);
        logic [PW-1:0] rt;
        logic          ack;
        rt  = rpc & ~64'h3;
        ack = ack_in && m_req;
        if (!m_started) begin
            m_started = 1'b1;
            if (rv) m_pend = rt;
            m_req  = 1'b1;
            m_addr = m_pend;
        end else if (m_ov) begin
            if (rv) begin
                m_ov = 1'b0; m_pend = rt; m_req = 1'b1; m_addr = rt;
            end else if (rdy) begin
                m_ov = 1'b0; m_req = 1'b1; m_addr = m_pend;
            end
        end else begin
            if (rv) m_pend = rt;
            if (ack) begin
                if (m_flush || rv) begin
                    m_flush = 1'b0;
                    m_addr  = m_pend;
                end else begin
                    m_ov = 1'b1; m_pc = m_addr; m_instr = rdata;
                    m_pend = m_addr + 64'd4; m_req = 1'b0;
                end
            end else if (rv) begin
                m_flush = 1'b1;
            end
        end
    endtask

    initial begin
        logic          mem_busy;
        int unsigned   mem_cnt, mem_lat;
        logic          ack, rv, rdy;
        logic [IW-1:0] rdata;
        logic [PW-1:0] rpc;

        reset_n = 1'b0;
        drive(1'b0, '0, 1'b0, '0, 1'b0);

        //   ack rdata        rv rpc                    rdy | req addr                   ov pc                     instr
        row(0, 32'h0,        0, 64'h0,                 0,   0, 64'h0,                 0, 64'h0,                 32'h0);
        row(1, 32'h00A30233, 0, 64'h0,                 0,   1, 64'h0,                 0, 64'h0,                 32'h0);
        row(0, 32'h0,        0, 64'h0,                 1,   0, 64'h0,                 1, 64'h0,                 32'h00A30233);
        row(1, 32'h402083B3, 0, 64'h0,                 0,   1, 64'h4,                 0, 64'h0,                 32'h00A30233);
        row(0, 32'h0,        0, 64'h0,                 1,   0, 64'h4,                 1, 64'h4,                 32'h402083B3);
        row(1, 32'hDEADBEEF, 0, 64'h0,                 0,   1, 64'h8,                 0, 64'h4,                 32'h402083B3);
        row(0, 32'h0,        0, 64'h0,                 0,   0, 64'h8,                 1, 64'h8,                 32'hDEADBEEF);
        row(1, 32'hBAD0BAD0, 0, 64'h0,                 0,   0, 64'h8,                 1, 64'h8,                 32'hDEADBEEF);
        row(0, 32'h0,        0, 64'h0,                 0,   0, 64'h8,                 1, 64'h8,                 32'hDEADBEEF);
        row(0, 32'h0,        0, 64'h0,                 0,   0, 64'h8,                 1, 64'h8,                 32'hDEADBEEF);
        row(0, 32'h0,        0, 64'h0,                 0,   0, 64'h8,                 1, 64'h8,                 32'hDEADBEEF);
        row(0, 32'h0,        0, 64'h0,                 1,   0, 64'h8,                 1, 64'h8,                 32'hDEADBEEF);
        row(0, 32'h0,        0, 64'h0,                 0,   1, 64'hC,                 0, 64'h8,                 32'hDEADBEEF);
        row(1, 32'h11111111, 0, 64'h0,                 0,   1, 64'hC,                 0, 64'h8,                 32'hDEADBEEF);
        row(0, 32'h0,        1, 64'h103,               1,   0, 64'hC,                 1, 64'hC,                 32'h11111111);
        row(1, 32'h22222222, 1, 64'h10,                0,   1, 64'h100,               0, 64'hC,                 32'h11111111);
        row(0, 32'h0,        0, 64'h0,                 0,   1, 64'h10,                0, 64'hC,                 32'h11111111);
        row(0, 32'h0,        1, 64'h40,                0,   1, 64'h10,                0, 64'hC,                 32'h11111111);
        row(1, 32'h33333333, 0, 64'h0,                 0,   1, 64'h10,                0, 64'hC,                 32'h11111111);
        row(1, 32'h44444444, 0, 64'h0,                 0,   1, 64'h40,                0, 64'hC,                 32'h11111111);
        row(0, 32'h0,        0, 64'h0,                 1,   0, 64'h40,                1, 64'h40,                32'h44444444);
        row(0, 32'h0,        1, 64'h80,                0,   1, 64'h44,                0, 64'h40,                32'h44444444);
        row(0, 32'h0,        1, 64'h90,                0,   1, 64'h44,                0, 64'h40,                32'h44444444);
        row(1, 32'h55555555, 0, 64'h0,                 0,   1, 64'h44,                0, 64'h40,                32'h44444444);
        row(1, 32'h66666666, 0, 64'h0,                 0,   1, 64'h90,                0, 64'h40,                32'h44444444);
        row(0, 32'h0,        1, 64'hFFFFFFFFFFFFFFFC,  0,   0, 64'h90,                1, 64'h90,                32'h66666666);
        row(1, 32'h77777777, 0, 64'h0,                 0,   1, 64'hFFFFFFFFFFFFFFFC,  0, 64'h90,                32'h66666666);
        row(0, 32'h0,        0, 64'h0,                 1,   0, 64'hFFFFFFFFFFFFFFFC,  1, 64'hFFFFFFFFFFFFFFFC,  32'h77777777);
        row(1, 32'h88888888, 0, 64'h0,                 0,   1, 64'h0,                 0, 64'hFFFFFFFFFFFFFFFC,  32'h77777777);
        row(0, 32'h0,        0, 64'h0,                 1,   0, 64'h0,                 1, 64'h0,                 32'h88888888);
        row(0, 32'h0,        0, 64'h0,                 0,   1, 64'h4,                 0, 64'h0,                 32'h88888888);

        repeat (2) @(negedge Clk);
        check("reset_state", 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            check($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_ov,
                  vecs[i].e_pc, vecs[i].e_instr);
            drive(vecs[i].ack, vecs[i].rdata, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
            @(negedge Clk);
        end

        // Reset asserted while a fetch of 0x4 is outstanding.
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        check("pre_midreset", 1'b1, 64'h4, 1'b0, 64'h0, 32'h88888888);
        #2 reset_n = 1'b0;
        #1 check("midreset_async", 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
        @(negedge Clk);
        reset_n = 1'b1;
        check("post_reset_boot", 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
        @(negedge Clk);
        check("post_reset_fetch", 1'b1, 64'h0, 1'b0, 64'h0, 32'h0);

        // Randomized run against the reference model.
        reset_n = 1'b0;
        @(negedge Clk);
        reset_n = 1'b1;
        model_reset();
        mem_busy = 1'b0;
        mem_cnt  = 0;
        mem_lat  = 0;
        for (int c = 0; c < 3000; c++) begin
            check($sformatf("rand%0d", c), m_req, m_addr, m_ov, m_pc, m_instr);
            ack   = 1'b0;
            rdata = $urandom;
            if (m_req) begin
                if (!mem_busy) begin
                    mem_busy = 1'b1;
                    mem_cnt  = 0;
                    mem_lat  = $urandom_range(0, 3);
                end
                if (mem_cnt == mem_lat) begin
                    ack      = 1'b1;
                    rdata    = mem_word(m_addr);
                    mem_busy = 1'b0;
                end else begin
                    mem_cnt++;
                end
            end else begin
                ack = ($urandom_range(0, 7) == 0);
            end
            rv  = ($urandom_range(0, 11) == 0);
            rpc = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rpc = 64'hFFFFFFFFFFFFFFF0 | 64'($urandom_range(0, 15));
            rdy = ($urandom_range(0, 3) != 0);
            drive(ack, rdata, rv, rpc, rdy);
            model_step(ack, rdata, rv, rpc, rdy);
            @(negedge Clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
